rs_pool: RTL and testbench

//  Parametrised reservation station for the Tomasulo core: replaces the fixed per-FU RS

---
 rtl/rs_pool_if.sv | 43 ++++
 rtl/rs_pool.sv | 111 +++++++++++
 tb/tb_rs_pool.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/rs_pool_if.sv
// rs_pool_if: issue, CDB snoop and dispatch signals of one reservation-station pool
interface rs_pool_if #(
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 3,
    parameter int OP_W    = 4,
    parameter int NUM_CDB = 3
) ();
    logic                      flush;
    logic                      issue_we;
    logic [OP_W-1:0]           issue_op;
    logic [DATA_W-1:0]         issue_vj;
    logic                      issue_qj_busy;
    logic [TAG_W-1:0]          issue_qj;
    logic [DATA_W-1:0]         issue_vk;
    logic                      issue_qk_busy;
    logic [TAG_W-1:0]          issue_qk;
    logic [TAG_W-1:0]          issue_dest;
    logic                      full;
    logic                      empty;
    logic [NUM_CDB-1:0]        cdb_valid;
    logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
    logic [NUM_CDB*DATA_W-1:0] cdb_data;
    logic                      fu_ready;
    logic                      disp_valid;
    logic [OP_W-1:0]           disp_op;
    logic [DATA_W-1:0]         disp_vj;
    logic [DATA_W-1:0]         disp_vk;
    logic [TAG_W-1:0]          disp_dest;

    modport slave (
        input  flush, issue_we, issue_op, issue_vj, issue_qj_busy, issue_qj,
               issue_vk, issue_qk_busy, issue_qk, issue_dest,
               cdb_valid, cdb_tag, cdb_data, fu_ready,
        output full, empty, disp_valid, disp_op, disp_vj, disp_vk, disp_dest
    );

    modport master (
        output flush, issue_we, issue_op, issue_vj, issue_qj_busy, issue_qj,
               issue_vk, issue_qk_busy, issue_qk, issue_dest,
               cdb_valid, cdb_tag, cdb_data, fu_ready,
        input  full, empty, disp_valid, disp_op, disp_vj, disp_vk, disp_dest
    );
endinterface

// File: rtl/rs_pool.sv
// rs_pool: generic collapsing-queue reservation station snooping NUM_CDB result buses
module rs_pool #(
    parameter int DEPTH   = 4,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 3,
    parameter int OP_W    = 4,
    parameter int NUM_CDB = 3
) (
    input logic     clk,
    input logic     rst,
    rs_pool_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] vj;
        logic              qj_busy;
        logic [TAG_W-1:0]  qj;
        logic [DATA_W-1:0] vk;
        logic              qk_busy;
        logic [TAG_W-1:0]  qk;
        logic [TAG_W-1:0]  dest;
    } entry_t;

    entry_t        slot [DEPTH];
    entry_t        woke [DEPTH];
    entry_t        nxt  [DEPTH];
    entry_t        ent;
    logic [CW-1:0] count, n_count, tail;
    logic [IW-1:0] sel;
    logic          found, do_disp, do_iss;

    // Channels are scanned high to low so the lowest matching channel lands last and wins.
    function automatic entry_t wake(entry_t e, logic [NUM_CDB-1:0] v,
                                    logic [NUM_CDB*TAG_W-1:0] t, logic [NUM_CDB*DATA_W-1:0] d);
        entry_t r;
        r = e;
        for (int c = NUM_CDB - 1; c >= 0; c--) begin
            if (e.qj_busy && v[c] && e.qj == t[c*TAG_W +: TAG_W]) begin
                r.vj      = d[c*DATA_W +: DATA_W];
                r.qj_busy = 1'b0;
            end
            if (e.qk_busy && v[c] && e.qk == t[c*TAG_W +: TAG_W]) begin
                r.vk      = d[c*DATA_W +: DATA_W];
                r.qk_busy = 1'b0;
            end
        end
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            woke[i] = wake(slot[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    end

    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (CW'(i) < count && !slot[i].qj_busy && !slot[i].qk_busy) begin
                found = 1'b1;
                sel   = IW'(i);
            end
        do_disp = bus.fu_ready && found && !bus.flush;
        do_iss  = bus.issue_we && !bus.full && !bus.flush;
        tail    = count - CW'(do_disp);
        n_count = bus.flush ? '0 : count + CW'(do_iss) - CW'(do_disp);
        ent     = {bus.issue_op, bus.issue_vj, bus.issue_qj_busy, bus.issue_qj,
                   bus.issue_vk, bus.issue_qk_busy, bus.issue_qk, bus.issue_dest};
    end

    // Entries above the dispatched slot collapse down; the new entry lands after the shift.
    always_comb begin
        for (int i = 0; i < DEPTH - 1; i++)
            nxt[i] = (do_disp && IW'(i) >= sel) ? woke[i+1] : woke[i];
        nxt[DEPTH-1] = woke[DEPTH-1];
        for (int i = 0; i < DEPTH; i++)
            if (do_iss && CW'(i) == tail)
                nxt[i] = wake(ent, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count          <= '0;
            bus.full       <= 1'b0;
            bus.empty      <= 1'b1;
            bus.disp_valid <= 1'b0;
            bus.disp_op    <= '0;
            bus.disp_vj    <= '0;
            bus.disp_vk    <= '0;
            bus.disp_dest  <= '0;
            for (int i = 0; i < DEPTH; i++)
                slot[i] <= '0;
        end else begin
            count          <= n_count;
            bus.full       <= n_count == CW'(DEPTH);
            bus.empty      <= n_count == '0;
            bus.disp_valid <= do_disp;
            for (int i = 0; i < DEPTH; i++)
                slot[i] <= nxt[i];
            if (do_disp) begin
                bus.disp_op   <= slot[sel].op;
                bus.disp_vj   <= slot[sel].vj;
                bus.disp_vk   <= slot[sel].vk;
                bus.disp_dest <= slot[sel].dest;
            end
        end
    end
endmodule

// File: tb/tb_rs_pool.sv
// tb_rs_pool: directed scenarios plus randomized traffic against a queue-based model of rs_pool
module tb_rs_pool;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rs_pool_if #(.DATA_W(32), .TAG_W(3), .OP_W(4), .NUM_CDB(3)) bus ();
    rs_pool #(.DEPTH(4), .DATA_W(32), .TAG_W(3), .OP_W(4), .NUM_CDB(3)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] vj, vk;
        logic        jb, kb;
        logic [2:0]  qj, qk, dest;
    } ent_t;

    ent_t        q[$];
    ent_t        ne;
    int          n0, idx;
    logic        m_dv;
    logic [3:0]  m_op;
    logic [31:0] m_vj, m_vk;
    logic [2:0]  m_dest;

    function automatic ent_t tb_wake(ent_t e);
        for (int c = 0; c < 3; c++) begin
            if (e.jb && bus.cdb_valid[c] && bus.cdb_tag[c*3 +: 3] == e.qj) begin e.vj = bus.cdb_data[c*32 +: 32]; e.jb = 1'b0; end
            if (e.kb && bus.cdb_valid[c] && bus.cdb_tag[c*3 +: 3] == e.qk) begin e.vk = bus.cdb_data[c*32 +: 32]; e.kb = 1'b0; end
        end
        return e;
    endfunction

    task automatic model_reset();
        q.delete(); m_dv = 0; m_op = 0; m_vj = 0; m_vk = 0; m_dest = 0;
    endtask

    // Expected state after the coming edge, from the current (stable) inputs.
    task automatic model_step();
        if (!rst) model_reset();
        else if (bus.flush) begin q.delete(); m_dv = 0; end
        else begin
            n0 = q.size(); idx = -1;
            if (bus.fu_ready)
                for (int i = 0; i < q.size(); i++) if (idx < 0 && !q[i].jb && !q[i].kb) idx = i;
            m_dv = idx >= 0;
            if (idx >= 0) begin
                m_op = q[idx].op; m_vj = q[idx].vj; m_vk = q[idx].vk; m_dest = q[idx].dest;
                q.delete(idx);
            end
            foreach (q[i]) q[i] = tb_wake(q[i]);
            if (bus.issue_we && n0 < 4) begin
                ne.op = bus.issue_op; ne.vj = bus.issue_vj; ne.jb = bus.issue_qj_busy; ne.qj = bus.issue_qj;
                ne.vk = bus.issue_vk; ne.kb = bus.issue_qk_busy; ne.qk = bus.issue_qk; ne.dest = bus.issue_dest;
                q.push_back(tb_wake(ne));
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.flush = 0; bus.issue_we = 0; bus.issue_op = 0; bus.issue_vj = 0; bus.issue_qj_busy = 0;
        bus.issue_qj = 0; bus.issue_vk = 0; bus.issue_qk_busy = 0; bus.issue_qk = 0; bus.issue_dest = 0;
        bus.cdb_valid = 0; bus.cdb_tag = 0; bus.cdb_data = 0; bus.fu_ready = 0;
    endtask

    task automatic iss(input logic [3:0] op, input logic [31:0] vj, input logic jb, input logic [2:0] qj,
                       input logic [31:0] vk, input logic kb, input logic [2:0] qk, input logic [2:0] dest);
        bus.issue_we = 1; bus.issue_op = op; bus.issue_vj = vj; bus.issue_qj_busy = jb; bus.issue_qj = qj;
        bus.issue_vk = vk; bus.issue_qk_busy = kb; bus.issue_qk = qk; bus.issue_dest = dest;
    endtask

    task automatic cdb(input int c, input logic [2:0] tag, input logic [31:0] data);
        bus.cdb_valid[c] = 1'b1; bus.cdb_tag[c*3 +: 3] = tag; bus.cdb_data[c*32 +: 32] = data;
    endtask

    task automatic test_reset();
        rst = 0; idle(); model_reset();
        repeat (2) @(negedge clk);
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", bus.empty); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", bus.full); end
        checks++; if (bus.disp_valid !== 1'b0) begin errors++; $display("FAIL reset_dv got %b want 0", bus.disp_valid); end
        checks++; if (bus.disp_dest !== 3'd0) begin errors++; $display("FAIL reset_dest got %0d want 0", bus.disp_dest); end
        rst = 1;
        for (int i = 0; i < 3; i++) begin iss(4'(i + 1), 32'(i), 0, 0, 32'(i), 0, 0, 3'(i + 1)); cycle(); end
        idle();
        checks++; if (bus.empty !== 1'b0) begin errors++; $display("FAIL reset_pre_empty got %b want 0", bus.empty); end
        #1 rst = 0; model_reset();
        #1;
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_async_empty got %b want 1", bus.empty); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_async_full got %b want 0", bus.full); end
        checks++; if (bus.disp_valid !== 1'b0) begin errors++; $display("FAIL reset_async_dv got %b want 0", bus.disp_valid); end
        @(negedge clk); rst = 1;
        iss(4'd9, 32'd11, 0, 0, 32'd22, 0, 0, 3'd6); bus.fu_ready = 1;
        cycle(); bus.issue_we = 0;
        checks++; if (bus.disp_valid !== 1'b0) begin errors++; $display("FAIL reset_lat1 got %b want 0", bus.disp_valid); end
        cycle();
        checks++; if (bus.disp_valid !== 1'b1) begin errors++; $display("FAIL reset_lat2 got %b want 1", bus.disp_valid); end
        checks++; if (bus.disp_dest !== 3'd6) begin errors++; $display("FAIL reset_dest6 got %0d want 6", bus.disp_dest); end
        checks++; if (bus.disp_vj !== 32'd11) begin errors++; $display("FAIL reset_vj got %0d want 11", bus.disp_vj); end
        idle(); cycle();
    endtask

    task automatic test_order();
        iss(4'd1, 32'd100, 0, 0, 32'd200, 0, 0, 3'd1); cycle();
        iss(4'd2, 32'd101, 0, 0, 32'd201, 0, 0, 3'd2); cycle();
        idle();
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++; if (bus.disp_valid !== 1'b0) begin errors++; $display("FAIL order_hold%0d got %b want 0", i, bus.disp_valid); end
        end
        bus.fu_ready = 1; cycle();
        checks++; if (bus.disp_valid !== 1'b1 || bus.disp_dest !== 3'd1) begin errors++; $display("FAIL order_first got v=%b d=%0d want v=1 d=1", bus.disp_valid, bus.disp_dest); end
        cycle();
        checks++; if (bus.disp_valid !== 1'b1 || bus.disp_dest !== 3'd2) begin errors++; $display("FAIL order_second got v=%b d=%0d want v=1 d=2", bus.disp_valid, bus.disp_dest); end
        checks++; if (bus.disp_op !== 4'd2 || bus.disp_vk !== 32'd201) begin errors++; $display("FAIL order_fields got op=%0d vk=%0d want op=2 vk=201", bus.disp_op, bus.disp_vk); end
        cycle();
        checks++; if (bus.disp_valid !== 1'b0 || bus.disp_dest !== 3'd2) begin errors++; $display("FAIL order_idle got v=%b d=%0d want v=0 d=2", bus.disp_valid, bus.disp_dest); end
        idle(); cycle();
    endtask

    task automatic test_wakeup();
        iss(4'd3, 32'd0, 1, 3'd6, 32'd1, 0, 0, 3'd4); cycle();
        iss(4'd4, 32'd0, 1, 3'd5, 32'd3, 0, 0, 3'd5); cycle();
        idle(); cdb(2, 3'd5, 32'hDEAD); cycle();
        idle(); bus.fu_ready = 1; cycle();
        checks++; if (bus.disp_valid !== 1'b1 || bus.disp_dest !== 3'd5) begin errors++; $display("FAIL wake_skip got v=%b d=%0d want v=1 d=5", bus.disp_valid, bus.disp_dest); end
        checks++; if (bus.disp_vj !== 32'hDEAD) begin errors++; $display("FAIL wake_vj got %h want dead", bus.disp_vj); end
        cycle();
        checks++; if (bus.disp_valid !== 1'b0) begin errors++; $display("FAIL wake_wait got %b want 0", bus.disp_valid); end
        cdb(1, 3'd6, 32'h1234); cycle();
        checks++; if (bus.disp_valid !== 1'b0) begin errors++; $display("FAIL wake_capture got %b want 0", bus.disp_valid); end
        idle(); bus.fu_ready = 1; cycle();
        checks++; if (bus.disp_valid !== 1'b1 || bus.disp_dest !== 3'd4 || bus.disp_vj !== 32'h1234) begin errors++; $display("FAIL wake_slot0 got v=%b d=%0d vj=%h want v=1 d=4 vj=1234", bus.disp_valid, bus.disp_dest, bus.disp_vj); end
        idle(); cycle();
    endtask

    task automatic test_bypass();
        iss(4'd5, 32'd8, 0, 0, 32'd0, 1, 3'd3, 3'd7); cdb(0, 3'd3, 32'd7); cdb(1, 3'd3, 32'd9); bus.fu_ready = 1;
        cycle();
        idle(); bus.fu_ready = 1;
        checks++; if (bus.disp_valid !== 1'b0) begin errors++; $display("FAIL bypass_lat got %b want 0", bus.disp_valid); end
        cycle();
        checks++; if (bus.disp_valid !== 1'b1 || bus.disp_dest !== 3'd7) begin errors++; $display("FAIL bypass_disp got v=%b d=%0d want v=1 d=7", bus.disp_valid, bus.disp_dest); end
        checks++; if (bus.disp_vk !== 32'd7) begin errors++; $display("FAIL bypass_vk got %0d want 7", bus.disp_vk); end
        idle(); cycle();
    endtask

    task automatic test_full();
        for (int i = 0; i < 5; i++) begin
            iss(4'd6, 32'(i), 0, 0, 32'(i), 0, 0, 3'(i + 1)); cycle();
            if (i >= 3) begin checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL full_flag%0d got %b want 1", i, bus.full); end end
        end
        idle(); bus.fu_ready = 1;
        for (int k = 1; k <= 4; k++) begin
            cycle();
            checks++; if (bus.disp_valid !== 1'b1 || bus.disp_dest !== 3'(k)) begin errors++; $display("FAIL full_drain%0d got v=%b d=%0d want v=1 d=%0d", k, bus.disp_valid, bus.disp_dest, k); end
        end
        cycle();
        checks++; if (bus.disp_valid !== 1'b0 || bus.empty !== 1'b1) begin errors++; $display("FAIL full_dropped got v=%b e=%b want v=0 e=1", bus.disp_valid, bus.empty); end
        idle();
        for (int i = 0; i < 3; i++) begin iss(4'd7, 0, 0, 0, 0, 0, 0, 3'(i + 1)); cycle(); end
        iss(4'd7, 0, 0, 0, 0, 0, 0, 3'd4); bus.fu_ready = 1; cycle();
        checks++; if (bus.disp_valid !== 1'b1 || bus.disp_dest !== 3'd1 || bus.full !== 1'b0) begin errors++; $display("FAIL full_swap got v=%b d=%0d f=%b want v=1 d=1 f=0", bus.disp_valid, bus.disp_dest, bus.full); end
        idle(); bus.fu_ready = 1;
        for (int k = 2; k <= 4; k++) begin
            cycle();
            checks++; if (bus.disp_valid !== 1'b1 || bus.disp_dest !== 3'(k)) begin errors++; $display("FAIL full_shift%0d got v=%b d=%0d want v=1 d=%0d", k, bus.disp_valid, bus.disp_dest, k); end
        end
        cycle();
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL full_end_empty got %b want 1", bus.empty); end
        idle(); cycle();
    endtask

    task automatic test_flush();
        iss(4'd8, 0, 0, 0, 0, 0, 0, 3'd1); cycle();
        iss(4'd8, 0, 0, 0, 0, 0, 0, 3'd2); cycle();
        iss(4'd8, 0, 0, 0, 0, 0, 0, 3'd3); bus.flush = 1; bus.fu_ready = 1; cycle();
        idle(); bus.fu_ready = 1;
        checks++; if (bus.empty !== 1'b1 || bus.disp_valid !== 1'b0 || bus.full !== 1'b0) begin errors++; $display("FAIL flush_next got e=%b v=%b f=%b want e=1 v=0 f=0", bus.empty, bus.disp_valid, bus.full); end
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++; if (bus.disp_valid !== 1'b0) begin errors++; $display("FAIL flush_nodisp%0d got %b want 0", i, bus.disp_valid); end
        end
        idle(); cycle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            idle();
            bus.flush = $urandom_range(0, 39) == 0;
            if ($urandom_range(0, 1) == 1)
                iss(4'($urandom), $urandom, $urandom_range(0, 2) == 0, 3'($urandom), $urandom,
                    $urandom_range(0, 2) == 0, 3'($urandom), 3'($urandom));
            for (int c = 0; c < 3; c++) if ($urandom_range(0, 1) == 1) cdb(c, 3'($urandom), $urandom);
            bus.fu_ready = $urandom_range(0, 3) != 0;
            cycle();
            checks++; if (bus.disp_valid !== m_dv) begin errors++; $display("FAIL rand_dv@%0d got %b want %b", n, bus.disp_valid, m_dv); end
            checks++; if (bus.disp_dest !== m_dest || bus.disp_op !== m_op) begin errors++; $display("FAIL rand_dest@%0d got d=%0d op=%0d want d=%0d op=%0d", n, bus.disp_dest, bus.disp_op, m_dest, m_op); end
            checks++; if (bus.disp_vj !== m_vj || bus.disp_vk !== m_vk) begin errors++; $display("FAIL rand_data@%0d got vj=%h vk=%h want vj=%h vk=%h", n, bus.disp_vj, bus.disp_vk, m_vj, m_vk); end
            checks++; if (bus.full !== (q.size() == 4) || bus.empty !== (q.size() == 0)) begin errors++; $display("FAIL rand_count@%0d got f=%b e=%b want size %0d", n, bus.full, bus.empty, q.size()); end
        end
        idle(); cycle();
    endtask

    initial begin
        test_reset();
        test_order();
        test_wakeup();
        test_bypass();
        test_full();
        test_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
